// File: rtl/conv_block_scheduler.sv
// Sequencer that walks the 2D-convolution address FSM through load, process and
// readback for each image block, with host strobe gating, block counting and a stall watchdog.
module conv_block_scheduler #(
  parameter int                    NB_BLOCKS  = 8,
  parameter int                    N_READ     = 2,
  parameter int                    NB_TIMEOUT = 16,
  parameter logic [NB_TIMEOUT-1:0] TIMEOUT    = 16'd50000,
  parameter int                    GAP        = 2
) (
  input  logic                 i_CLK,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [NB_BLOCKS-1:0] i_nBlocks,
  input  logic                 i_abort,
  input  logic                 i_hostValid,
  input  logic                 i_changeBlock,
  output logic                 o_load,
  output logic                 o_SoP,
  output logic                 o_valid,
  output logic                 o_fsmReset,
  output logic [1:0]           o_phase,
  output logic [NB_BLOCKS-1:0] o_blockIdx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int RD_W  = (N_READ > 1) ? $clog2(N_READ) : 1;
  localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [RD_W-1:0]       RD_LAST  = RD_W'(N_READ - 1);
  localparam logic [NB_TIMEOUT-1:0] WD_LAST  = TIMEOUT - NB_TIMEOUT'(1);
  localparam logic [NB_BLOCKS-1:0]  BLK_ONE  = NB_BLOCKS'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GAP_L = 3'd1,
    S_LOAD  = 3'd2,
    S_GAP_P = 3'd3,
    S_PROC  = 3'd4,
    S_GAP_R = 3'd5,
    S_READ  = 3'd6,
    S_NEXT  = 3'd7
  } state_t;

  state_t                 state_q, state_d;
  logic                   cb_q;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [RD_W-1:0]        rd_q, rd_d;
  logic [NB_TIMEOUT-1:0]  wd_q, wd_d;
  logic [NB_BLOCKS-1:0]   nblocks_q, nblocks_d;
  logic [NB_BLOCKS-1:0]   block_idx_q, block_idx_d;
  logic                   load_q, load_d;
  logic                   sop_q, sop_d;
  logic                   valid_q, valid_d;
  logic                   fsm_reset_q, fsm_reset_d;
  logic [1:0]             phase_q, phase_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   cb_rise;
  logic                   active;
  logic                   wd_expire;

  assign cb_rise   = i_changeBlock & ~cb_q;
  assign active    = (state_q == S_LOAD) || (state_q == S_PROC) || (state_q == S_READ);
  assign wd_expire = (wd_q == WD_LAST);

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    rd_d        = rd_q;
    wd_d        = wd_q;
    nblocks_d   = nblocks_q;
    block_idx_d = block_idx_q;
    fsm_reset_d = 1'b0;
    done_d      = 1'b0;
    error_d     = error_q;

    if (active) begin
      if (cb_rise) begin
        wd_d = '0;
      end else begin
        wd_d = wd_q + NB_TIMEOUT'(1);
      end
    end else begin
      wd_d = wd_q;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_nBlocks != '0) begin
            nblocks_d   = i_nBlocks;
            block_idx_d = '0;
            error_d     = 1'b0;
            fsm_reset_d = 1'b1;
            state_d     = S_GAP_L;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP_L, S_GAP_P, S_GAP_R: begin
        if (gap_q == GAP_LAST) begin
          case (state_q)
            S_GAP_L: state_d = S_LOAD;
            S_GAP_P: state_d = S_PROC;
            default: state_d = S_READ;
          endcase
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_LOAD, S_PROC, S_READ: begin
        // A changeBlock edge outranks a watchdog expiry landing on the same cycle.
        if (cb_rise) begin
          if (state_q == S_LOAD) begin
            state_d = S_GAP_P;
          end else if (state_q == S_PROC) begin
            state_d = S_GAP_R;
          end else if (rd_q == RD_LAST) begin
            state_d = S_NEXT;
          end else begin
            rd_d = rd_q + RD_W'(1);
          end
        end else if (wd_expire) begin
          error_d     = 1'b1;
          fsm_reset_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      S_NEXT: begin
        if (block_idx_q == nblocks_q - BLK_ONE) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          block_idx_d = block_idx_q + BLK_ONE;
          state_d     = S_GAP_L;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (i_abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      fsm_reset_d = 1'b1;
      done_d      = 1'b0;
      error_d     = error_q;
    end else begin
      error_d = error_d;
    end

    if (state_d != state_q) begin
      gap_d = '0;
      rd_d  = '0;
      wd_d  = '0;
    end else begin
      gap_d = gap_d;
    end

    if (state_d == S_IDLE) begin
      block_idx_d = '0;
    end else begin
      block_idx_d = block_idx_d;
    end

    case (state_d)
      S_LOAD:  phase_d = 2'b01;
      S_PROC:  phase_d = 2'b10;
      S_READ:  phase_d = 2'b11;
      default: phase_d = 2'b00;
    endcase

    load_d  = (state_d == S_LOAD);
    sop_d   = (state_d == S_PROC);
    busy_d  = (state_d != S_IDLE);
    // Strobes pass only while staying in a data phase, so no edge leaks into a gap.
    valid_d = i_hostValid && (state_d == state_q) &&
              ((state_q == S_LOAD) || (state_q == S_READ));
  end

  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      cb_q        <= 1'b0;
      gap_q       <= '0;
      rd_q        <= '0;
      wd_q        <= '0;
      nblocks_q   <= '0;
      block_idx_q <= '0;
      load_q      <= 1'b0;
      sop_q       <= 1'b0;
      valid_q     <= 1'b0;
      fsm_reset_q <= 1'b0;
      phase_q     <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cb_q        <= i_changeBlock;
      gap_q       <= gap_d;
      rd_q        <= rd_d;
      wd_q        <= wd_d;
      nblocks_q   <= nblocks_d;
      block_idx_q <= block_idx_d;
      load_q      <= load_d;
      sop_q       <= sop_d;
      valid_q     <= valid_d;
      fsm_reset_q <= fsm_reset_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign o_load     = load_q;
  assign o_SoP      = sop_q;
  assign o_valid    = valid_q;
  assign o_fsmReset = fsm_reset_q;
  assign o_phase    = phase_q;
  assign o_blockIdx = block_idx_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;

endmodule

// File: tb/tb_conv_block_scheduler.sv
// Bench for conv_block_scheduler: directed scenarios plus random traffic, all checked
// every cycle against a countdown-style behavioural model.
module tb_conv_block_scheduler;

  localparam int M_GAP = 2;
  localparam int M_NREAD = 2;
  localparam int M_TIMEOUT = 20;

  logic       i_CLK = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic [7:0] i_nBlocks;
  logic       i_abort;
  logic       i_hostValid;
  logic       i_changeBlock;
  logic       o_load, o_SoP, o_valid, o_fsmReset, o_busy, o_done, o_error;
  logic [1:0] o_phase;
  logic [7:0] o_blockIdx;

  conv_block_scheduler #(.TIMEOUT(16'd20)) dut (
    .i_CLK(i_CLK), .i_reset(i_reset), .i_start(i_start), .i_nBlocks(i_nBlocks),
    .i_abort(i_abort), .i_hostValid(i_hostValid), .i_changeBlock(i_changeBlock),
    .o_load(o_load), .o_SoP(o_SoP), .o_valid(o_valid), .o_fsmReset(o_fsmReset),
    .o_phase(o_phase), .o_blockIdx(o_blockIdx), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error)
  );

  always #5 i_CLK = ~i_CLK;

  int total = 0;
  int bad = 0;

  // Model: mode 0 idle, 1 gap countdown, 2 data phase, 3 next-block decision.
  int m_mode, m_phase, m_target, m_gap_left, m_reads, m_wd, m_n, m_idx;
  bit m_error, m_done, m_rst, m_valid, m_cbp;

  int  dones, loads, last_ph;
  bit  prev_load;
  int  ph_log[$];
  int  idx_log[$];
  bit  hv_toggle = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_target = 0; m_gap_left = 0; m_reads = 0; m_wd = 0;
    m_n = 0; m_idx = 0; m_error = 0; m_done = 0; m_rst = 0; m_valid = 0; m_cbp = 0;
  endtask

  task automatic go_gap(input int target);
    m_mode = 1; m_phase = 0; m_gap_left = M_GAP; m_target = target;
  endtask

  task automatic go_idle();
    m_mode = 0; m_phase = 0; m_idx = 0;
  endtask

  task automatic model_step();
    int  old_mode, old_phase;
    bit  rise;
    old_mode  = m_mode;
    old_phase = m_phase;
    rise      = i_changeBlock && !m_cbp;
    m_cbp     = i_changeBlock;
    m_done    = 0;
    m_rst     = 0;
    if (m_mode == 0) begin
      if (i_start) begin
        if (i_nBlocks != 0) begin
          m_n = i_nBlocks; m_idx = 0; m_error = 0; m_rst = 1; go_gap(1);
        end else begin
          m_done = 1;
        end
      end
    end else if (i_abort) begin
      m_rst = 1; go_idle();
    end else if (m_mode == 1) begin
      if (m_gap_left == 1) begin
        m_mode = 2; m_phase = m_target; m_wd = 0; m_reads = 0;
      end else begin
        m_gap_left--;
      end
    end else if (m_mode == 2) begin
      if (rise) begin
        m_wd = 0;
        if (m_phase == 1) go_gap(2);
        else if (m_phase == 2) go_gap(3);
        else begin
          m_reads++;
          if (m_reads == M_NREAD) begin m_mode = 3; m_phase = 0; end
        end
      end else begin
        m_wd++;
        if (m_wd == M_TIMEOUT) begin
          m_error = 1; m_rst = 1; go_idle();
        end
      end
    end else begin
      if (m_idx == m_n - 1) begin
        m_done = 1; go_idle();
      end else begin
        m_idx++; go_gap(1);
      end
    end
    m_valid = i_hostValid && old_mode == 2 && (old_phase == 1 || old_phase == 3) &&
              m_mode == 2 && m_phase == old_phase;
  endtask

  task automatic compare();
    chk("load",     o_load,     (m_mode == 2 && m_phase == 1));
    chk("sop",      o_SoP,      (m_mode == 2 && m_phase == 2));
    chk("valid",    o_valid,    m_valid);
    chk("fsmReset", o_fsmReset, m_rst);
    chk("phase",    o_phase,    m_phase);
    chk("blockIdx", o_blockIdx, m_idx);
    chk("busy",     o_busy,     (m_mode != 0));
    chk("done",     o_done,     m_done);
    chk("error",    o_error,    m_error);
    if (o_done) dones++;
    if (o_load && !prev_load) begin loads++; idx_log.push_back(o_blockIdx); end
    prev_load = o_load;
    if (o_phase != last_ph && o_phase != 0) ph_log.push_back(o_phase);
    last_ph = o_phase;
  endtask

  task automatic tick();
    if (hv_toggle) i_hostValid = ~i_hostValid;
    @(posedge i_CLK);
    model_step();
    @(negedge i_CLK);
    compare();
  endtask

  task automatic clear_logs();
    dones = 0; loads = 0; ph_log.delete(); idx_log.delete();
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while (o_phase != ph && n < 100) begin tick(); n++; end
    chk("wait_phase", o_phase, ph);
  endtask

  task automatic pulse_cb();
    i_changeBlock = 1'b1; tick();
    i_changeBlock = 1'b0; tick();
  endtask

  task automatic run_block();
    wait_phase(1); pulse_cb();
    wait_phase(2); pulse_cb();
    wait_phase(3); pulse_cb(); pulse_cb();
  endtask

  task automatic start_cmd(input int nb);
    i_start = 1'b1; i_nBlocks = 8'(nb); tick(); i_start = 1'b0;
  endtask

  initial begin
    int n;
    bit stuck;
    i_reset = 1'b1; i_start = 1'b0; i_nBlocks = 8'd0; i_abort = 1'b0;
    i_hostValid = 1'b0; i_changeBlock = 1'b0;
    prev_load = 0; last_ph = 0; clear_logs();
    model_reset();
    repeat (2) @(negedge i_CLK);
    compare();
    chk("reset_busy", o_busy, 0);
    chk("reset_phase", o_phase, 0);
    i_reset = 1'b0;
    tick();

    // Single block with latency pins.
    clear_logs();
    start_cmd(1);
    chk("start_rst", o_fsmReset, 1);
    chk("start_busy", o_busy, 1);
    n = 1;
    while (!o_load && n < 50) begin tick(); n++; end
    chk("load_lat", n, 1 + M_GAP);
    i_changeBlock = 1'b1; tick(); i_changeBlock = 1'b0;
    chk("load_drop", o_load, 0);
    n = 0;
    while (!o_SoP && n < 50) begin tick(); n++; end
    chk("sop_lat", n, M_GAP);
    pulse_cb();
    wait_phase(3); pulse_cb(); pulse_cb();
    tick();
    chk("single_dones", dones, 1);
    chk("single_busy", o_busy, 0);
    chk("ph_log_n", ph_log.size(), 3);
    if (ph_log.size() == 3) begin
      chk("ph_log0", ph_log[0], 1);
      chk("ph_log1", ph_log[1], 2);
      chk("ph_log2", ph_log[2], 3);
    end

    // Multi-block.
    clear_logs();
    start_cmd(3);
    repeat (3) run_block();
    tick(); tick();
    chk("multi_loads", loads, 3);
    chk("multi_dones", dones, 1);
    chk("multi_idx_n", idx_log.size(), 3);
    for (int i = 0; i < idx_log.size(); i++) chk("multi_idx", idx_log[i], i);

    // Zero blocks.
    clear_logs();
    start_cmd(0);
    chk("zero_done", o_done, 1);
    chk("zero_busy", o_busy, 0);
    tick(); tick();
    chk("zero_loads", loads, 0);

    // Watchdog in PROC.
    clear_logs();
    start_cmd(1);
    wait_phase(1); pulse_cb();
    wait_phase(2);
    n = 0;
    while (!o_error && n < 100) begin tick(); n++; end
    chk("wd_latency", n, M_TIMEOUT);
    chk("wd_rst", o_fsmReset, 1);
    chk("wd_busy", o_busy, 0);
    tick(); tick();
    chk("wd_no_done", dones, 0);
    start_cmd(1);
    chk("wd_clear", o_error, 0);

    // Abort in READ after one edge, then a clean restart.
    wait_phase(1); pulse_cb();
    wait_phase(2); pulse_cb();
    wait_phase(3);
    i_changeBlock = 1'b1; tick(); i_changeBlock = 1'b0;
    clear_logs();
    i_abort = 1'b1; tick(); i_abort = 1'b0;
    chk("abort_rst", o_fsmReset, 1);
    chk("abort_busy", o_busy, 0);
    tick(); tick();
    chk("abort_no_done", dones, 0);
    start_cmd(1);
    run_block();
    tick();
    chk("restart_done", dones, 1);

    // Asynchronous reset in the middle of LOAD.
    start_cmd(2);
    wait_phase(1); tick();
    #1 i_reset = 1'b1;
    #1;
    chk("arst_load", o_load, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_phase", o_phase, 0);
    chk("arst_valid", o_valid, 0);
    model_reset();
    @(negedge i_CLK);
    i_reset = 1'b0;
    compare();

    // Random traffic.
    hv_toggle = 1'b0;
    stuck = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) stuck = ($urandom_range(0, 2) == 0);
      i_start     = ($urandom_range(0, 9) == 0);
      i_nBlocks   = 8'($urandom_range(0, 3));
      i_abort     = ($urandom_range(0, 299) == 0);
      i_hostValid = 1'($urandom);
      if (!stuck && $urandom_range(0, 2) == 0) i_changeBlock = ~i_changeBlock;
      tick();
    end
    i_start = 1'b0; i_abort = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
